polar_encoder_sp: RTL and testbench
===================================

Name: polar_encoder_sp

Overview:
- Semi-parallel polar encoder; the transmit-side counterpart of the SC decoder's stage/exe scheduling.
- Accepts K serial information bits and inserts zeros at frozen positions to form u[0..N-1], where N = 2^n.
- Runs n butterfly stages at 2^p XOR butterflies per cycle, then streams the N-bit codeword x = u·F^{⊗n} serially.
- Exposes the same stage_index/exe_index schedule as the decoder, so encoder and decoder can be co-simulated stage-for-stage.

Parameters:
- n, 3, log2 of code length N; legal range n >= 2.
- p, 1, log2 of butterflies per cycle; legal range 0 <= p <= n-1.
- INFO_MASK, 8'b1110_1000, N-bit vector; bit i = 1 means position i carries information, 0 means frozen. K = popcount.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  info bit available
- in_ready  out  1  encoder accepts in_bit this cycle
- in_bit  in  1  next information bit, in ascending position order
- out_valid  out  1  codeword bit valid
- out_ready  in  1  downstream accepts out_bit
- out_bit  out  1  codeword bit x[out_index]
- out_index  out  n  position of out_bit
- busy  out  1  high during ENC (and CLR when enabled)
- stage_index  out  $clog2(n)  current butterfly stage
- exe_index  out  n-p  remaining executions in the current stage, counting down

Behaviour:
- Reset (rst=1 at a clk edge, from any state, including mid-ENC or mid-OUT):
  - state=LOAD, ptr=0, buffer v cleared to 0.
  - stage_index=n-1, exe_index=2^(n-p-1).
  - in_ready=0, out_valid=0, out_index=0, busy=0.
- State LOAD: ptr walks 0..N-1.
  - INFO_MASK[ptr]=0: write v[ptr]=0, ptr++, in_ready=0.
  - INFO_MASK[ptr]=1: in_ready=1 (combinational from state and mask). On in_valid&in_ready, write v[ptr]=in_bit and ptr++. Otherwise hold.
  - After ptr=N-1 is written: go to ENC, ptr=0.
  - Minimum LOAD time is N cycles.
- State ENC: one stage step per cycle.
  - Stage s=stage_index has span 2^s.
  - Butterfly j maps to i = ((j>>s)<<(s+1)) | (j & (2^s-1)).
  - Each cycle, for k=0..2^p-1, compute j = (2^(n-p-1)-exe_index)·2^p + k and set v[i] ^= v[i+2^s].
  - Schedule:
    - If exe_index>1: exe_index--.
    - Else if stage_index>0: stage_index--, exe_index=2^(n-p-1).
    - Else (stage 0, exe 1): leave ENC; stage_index=n-1, exe_index=2^(n-p-1).
  - Total ENC latency: n·2^(n-p-1) cycles (6 for the defaults).
  - Butterflies within a stage are disjoint, so all 2^p updates read the pre-cycle v.
- State OUT:
  - out_valid=1, out_bit=v[out_index].
  - On out_valid&out_ready, out_index++.
  - The beat with out_index=N-1 accepted: go to LOAD, out_index wraps to 0, v is cleared.
  - out_ready=0 holds out_bit and out_index stable.
- in_ready=0 outside LOAD.
- in_valid outside LOAD is ignored; no bit is consumed.
- All index arithmetic is modulo-width; there is no saturation.

Optional Feature:
- POLAR_ENC_SYSTEMATIC_EN defined: systematic encoding.
  - After the first ENC pass, enter CLR for 1 cycle and zero all v[i] with INFO_MASK[i]=0.
  - Then run a second ENC pass of identical schedule, then go to OUT.
  - Result: x[i] equals the corresponding info bit at every info position.
  - Latency: 2·n·2^(n-p-1)+1 cycles.
  - busy is high throughout CLR.
- Undefined: non-systematic; CLR state and the second pass are absent.

Test Plan:
- Defaults (n=3, p=1, mask 11101000), info bits 1,0,0,0 → x0..x7 = 1,1,1,1,0,0,0,0; busy high for exactly 6 cycles; stage_index sequence 2,2,1,1,0,0.
- Defaults, info bits 1,1,1,1 → x0..x7 = 0,1,1,0,1,0,0,1.
- p=2, same stimulus as the first scenario → same codeword; ENC lasts 3 cycles; exe_index is always 1.
- out_ready toggled 1,0,0,1,... during OUT → out_bit and out_index held while out_ready=0; full codeword delivered in order; then in_ready rises for position 3.
- rst pulsed on the 3rd ENC cycle → next cycle state=LOAD, outputs at reset values; a fresh frame with info bits 1,0,0,0 encodes to 11110000.
- POLAR_ENC_SYSTEMATIC_EN defined, info bits 1,0,0,0 → x = 1,1,1,1,0,0,0,0 (x3=1, x5=x6=x7=0); busy high for 13 cycles.

Source files
------------

// File: rtl/polar_encoder_sp.sv
// polar_encoder_sp: semi-parallel polar encoder.
// Information bits arrive serially. Zeros are inserted at the frozen positions
// of INFO_MASK to form u. The encoder then runs n XOR-butterfly stages at 2^p
// butterflies per cycle and streams x = u*F^{(x)n} serially.
// The stage_index/exe_index schedule matches the SC decoder schedule.
// Optional build macro: POLAR_ENC_SYSTEMATIC_EN selects systematic encoding.
// In that mode a CLR cycle zeroes the frozen positions and a second ENC pass runs.
module polar_encoder_sp #(
    parameter int                  n         = 3,
    parameter int                  p         = 1,
    parameter logic [(1<<n)-1:0]   INFO_MASK = 8'b1110_1000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_bit,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_bit,
    output logic [n-1:0]           out_index,
    output logic                   busy,
    output logic [$clog2(n)-1:0]   stage_index,
    output logic [n-p-1:0]         exe_index
);

    localparam int          N          = 1 << n;
    localparam int          SW         = $clog2(n);
    localparam int          EW         = n - p;
    localparam int unsigned BPC        = 1 << p;
    localparam logic [EW-1:0] EXE_INIT = EW'(1 << (n - p - 1));
    localparam logic [SW-1:0] STG_INIT = SW'(n - 1);
    localparam logic [n-1:0]  LAST     = '1;

    typedef enum logic [1:0] {
        S_LOAD,
        S_ENC,
`ifdef POLAR_ENC_SYSTEMATIC_EN
        S_CLR,
`endif
        S_OUT
    } state_t;

    state_t         state;
    logic [n-1:0]   ptr;
    logic [N-1:0]   v;
    logic [N-1:0]   v_bfly;
`ifdef POLAR_ENC_SYSTEMATIC_EN
    logic           second_pass;
`endif

    assign in_ready  = (state == S_LOAD) && INFO_MASK[ptr];
    assign out_valid = (state == S_OUT);
    assign out_bit   = v[out_index];
`ifdef POLAR_ENC_SYSTEMATIC_EN
    assign busy      = (state == S_ENC) || (state == S_CLR);
`else
    assign busy      = (state == S_ENC);
`endif

    // One execution of the current stage: 2^p disjoint butterflies, all reading pre-cycle v
    always_comb begin
        int unsigned s;
        int unsigned span;
        int unsigned base;
        int unsigned j;
        logic [n-1:0] lo;
        logic [n-1:0] hi;
        v_bfly = v;
        s      = 32'(stage_index);
        span   = 32'd1 << s;
        base   = (32'(EXE_INIT) - 32'(exe_index)) << p;
        j      = 0;
        lo     = '0;
        hi     = '0;
        for (int unsigned k = 0; k < BPC; k++) begin
            j  = base + k;
            lo = n'(((j >> s) << (s + 1)) | (j & (span - 1)));
            hi = n'(32'(lo) + span);
            v_bfly[lo] = v[lo] ^ v[hi];
        end
    end

    // Frame sequencer: LOAD -> ENC (-> CLR -> ENC) -> OUT -> LOAD
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_LOAD;
            ptr         <= '0;
            v           <= '0;
            stage_index <= STG_INIT;
            exe_index   <= EXE_INIT;
            out_index   <= '0;
`ifdef POLAR_ENC_SYSTEMATIC_EN
            second_pass <= 1'b0;
`endif
        end else begin
            case (state)
                S_LOAD: begin
                    // Frozen slots advance on their own; info slots wait for a valid bit
                    if (!INFO_MASK[ptr] || in_valid) begin
                        v[ptr] <= INFO_MASK[ptr] & in_bit;
                        ptr    <= ptr + 1'b1;
                        if (ptr == LAST) begin
                            state <= S_ENC;
                        end
                    end
                end
                S_ENC: begin
                    v <= v_bfly;
                    if (exe_index > EW'(1)) begin
                        exe_index <= exe_index - 1'b1;
                    end else if (stage_index != '0) begin
                        stage_index <= stage_index - 1'b1;
                        exe_index   <= EXE_INIT;
                    end else begin
                        stage_index <= STG_INIT;
                        exe_index   <= EXE_INIT;
`ifdef POLAR_ENC_SYSTEMATIC_EN
                        if (second_pass) begin
                            second_pass <= 1'b0;
                            state       <= S_OUT;
                        end else begin
                            state       <= S_CLR;
                        end
`else
                        state <= S_OUT;
`endif
                    end
                end
`ifdef POLAR_ENC_SYSTEMATIC_EN
                S_CLR: begin
                    v           <= v & INFO_MASK;
                    second_pass <= 1'b1;
                    state       <= S_ENC;
                end
`endif
                S_OUT: begin
                    if (out_ready) begin
                        out_index <= out_index + 1'b1;
                        if (out_index == LAST) begin
                            state <= S_LOAD;
                            v     <= '0;
                        end
                    end
                end
                default: state <= S_LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_polar_encoder_sp.sv
// tb_polar_encoder_sp: scoreboard bench for polar_encoder_sp.
// Two instances (p=1 and p=2) share the stimulus through a select mux.
// Expected codewords come from a generator-matrix model: x[j] = XOR of u[i] over i with (i & j) == j.
`timescale 1ns/1ps
module tb_polar_encoder_sp;

    localparam int         n    = 3;
    localparam int         N    = 8;
    localparam int         K    = 4;
    localparam logic [7:0] MASK = 8'b1110_1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sel = 1'b0;
    logic in_valid = 1'b0;
    logic in_bit = 1'b0;
    logic out_ready = 1'b0;

    int unsigned tests = 0;
    int unsigned fails = 0;
    logic [3:0]  sb[$];

    always #5 clk = ~clk;

    logic       iv0, or0, ir0, ov0, ob0, busy0;
    logic [2:0] oi0;
    logic [1:0] st0, ex0;
    logic       iv1, or1, ir1, ov1, ob1, busy1;
    logic [2:0] oi1;
    logic [1:0] st1;
    logic [0:0] ex1;

    assign iv0 = in_valid & ~sel;
    assign iv1 = in_valid & sel;
    assign or0 = out_ready & ~sel;
    assign or1 = out_ready & sel;

    polar_encoder_sp #(.n(3), .p(1), .INFO_MASK(MASK)) dut0 (
        .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(ir0), .in_bit(in_bit),
        .out_valid(ov0), .out_ready(or0), .out_bit(ob0), .out_index(oi0),
        .busy(busy0), .stage_index(st0), .exe_index(ex0)
    );

    polar_encoder_sp #(.n(3), .p(2), .INFO_MASK(MASK)) dut1 (
        .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(ir1), .in_bit(in_bit),
        .out_valid(ov1), .out_ready(or1), .out_bit(ob1), .out_index(oi1),
        .busy(busy1), .stage_index(st1), .exe_index(ex1)
    );

    logic       in_ready_m, out_valid_m, out_bit_m, busy_m;
    logic [2:0] out_index_m;
    logic [1:0] stage_m, exe_m;

    assign in_ready_m  = sel ? ir1   : ir0;
    assign out_valid_m = sel ? ov1   : ov0;
    assign out_bit_m   = sel ? ob1   : ob0;
    assign busy_m      = sel ? busy1 : busy0;
    assign out_index_m = sel ? oi1   : oi0;
    assign stage_m     = sel ? st1   : st0;
    assign exe_m       = sel ? {1'b0, ex1} : ex0;

    function automatic logic [N-1:0] xform(input logic [N-1:0] u);
        logic [N-1:0] x = '0;
        for (int j = 0; j < N; j++)
            for (int i = 0; i < N; i++)
                if ((i & j) == j) x[j] = x[j] ^ u[i];
        return x;
    endfunction

    function automatic logic [N-1:0] model(input logic [K-1:0] info);
        logic [N-1:0] u = '0;
        logic [N-1:0] x;
        int k = 0;
        for (int i = 0; i < N; i++)
            if (MASK[i]) begin
                u[i] = info[k];
                k++;
            end
        x = xform(u);
`ifdef POLAR_ENC_SYSTEMATIC_EN
        x = xform(x & MASK);
`endif
        return x;
    endfunction

    task automatic send_bit(input logic b);
        int unsigned t = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_bit   = b;
        while (!in_ready_m && t < 64) begin
            @(negedge clk);
            t++;
        end
        if (t >= 64) begin
            tests++;
            fails++;
            $display("FAIL send_bit: in_ready never rose, got 0 required 1");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [K-1:0] info, input bit push);
        logic [N-1:0] x;
        if (push) begin
            x = model(info);
            for (int i = 0; i < N; i++) sb.push_back({3'(i), x[i]});
        end
        for (int k = 0; k < K; k++) send_bit(info[k]);
    endtask

    // Collects one codeword; checks schedule, busy length, hold under stall, and scoreboard order
    task automatic collect_frame(input bit bp, input int exe_per_stage, input string name);
        int unsigned beats = 0, t = 0, cyc = 0, busy_cnt = 0, enc_len, passes;
        logic [1:0] st_exp[$];
        logic [1:0] ex_exp[$];
        logic [3:0] exp_e;
        logic       held_bit = 1'b0;
        logic [2:0] held_idx = '0;
        bit         stalled = 1'b0;
`ifdef POLAR_ENC_SYSTEMATIC_EN
        passes = 2;
`else
        passes = 1;
`endif
        for (int ps = 0; ps < int'(passes); ps++) begin
            if (ps > 0) begin
                st_exp.push_back(2'(n - 1));
                ex_exp.push_back(2'(exe_per_stage));
            end
            for (int s = n - 1; s >= 0; s--)
                for (int e = exe_per_stage; e >= 1; e--) begin
                    st_exp.push_back(2'(s));
                    ex_exp.push_back(2'(e));
                end
        end
        enc_len = st_exp.size();
        while (beats < N && t < 400) begin
            @(negedge clk);
            t++;
            if (busy_m) begin
                if (busy_cnt < enc_len) begin
                    tests++;
                    if (stage_m !== st_exp[busy_cnt] || exe_m !== ex_exp[busy_cnt]) begin
                        fails++;
                        $display("FAIL %s schedule[%0d]: stage=%0d exe=%0d, required stage=%0d exe=%0d",
                                 name, busy_cnt, stage_m, exe_m, st_exp[busy_cnt], ex_exp[busy_cnt]);
                    end
                end
                busy_cnt++;
            end
            if (out_valid_m) begin
                if (stalled) begin
                    tests++;
                    if (out_index_m !== held_idx || out_bit_m !== held_bit) begin
                        fails++;
                        $display("FAIL %s hold: idx=%0d bit=%b, required idx=%0d bit=%b",
                                 name, out_index_m, out_bit_m, held_idx, held_bit);
                    end
                end
                out_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
                cyc++;
                held_idx = out_index_m;
                held_bit = out_bit_m;
                stalled  = !out_ready;
                if (out_ready) begin
                    tests++;
                    if (sb.size() == 0) begin
                        fails++;
                        $display("FAIL %s scoreboard: beat %0d with empty queue", name, beats);
                    end else begin
                        exp_e = sb.pop_front();
                        if ({out_index_m, out_bit_m} !== exp_e) begin
                            fails++;
                            $display("FAIL %s x: idx=%0d bit=%b, required idx=%0d bit=%b",
                                     name, out_index_m, out_bit_m, exp_e[3:1], exp_e[0]);
                        end
                    end
                    beats++;
                end
            end else begin
                out_ready = 1'b0;
            end
        end
        if (beats < N) begin
            tests++;
            fails++;
            $display("FAIL %s timeout: %0d beats, required %0d", name, beats, N);
        end
        tests++;
        if (busy_cnt != enc_len) begin
            fails++;
            $display("FAIL %s busy_len: %0d cycles, required %0d", name, busy_cnt, enc_len);
        end
    endtask

    task automatic test_reset();
        logic [31:0] obs[8];
        logic [31:0] expv[8];
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        obs[0] = 32'(ir0);   expv[0] = 0;
        obs[1] = 32'(ov0);   expv[1] = 0;
        obs[2] = 32'(oi0);   expv[2] = 0;
        obs[3] = 32'(busy0); expv[3] = 0;
        obs[4] = 32'(st0);   expv[4] = 2;
        obs[5] = 32'(ex0);   expv[5] = 2;
        obs[6] = 32'(st1);   expv[6] = 2;
        obs[7] = 32'(ex1);   expv[7] = 1;
        for (int i = 0; i < 8; i++) begin
            tests++;
            if (obs[i] !== expv[i]) begin
                fails++;
                $display("FAIL reset[%0d]: got %0h required %0h", i, obs[i], expv[i]);
            end
        end
    endtask

    task automatic test_encode(input logic [K-1:0] info, input logic which, input string name);
        sel = which;
        send_frame(info, 1'b1);
        collect_frame(1'b0, which ? 1 : 2, name);
    endtask

    task automatic test_backpressure();
        logic expr[4];
        sel = 1'b0;
        send_frame(4'b0110, 1'b1);
        collect_frame(1'b1, 2, "backpressure");
        expr = '{1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            tests++;
            if (in_ready_m !== expr[i]) begin
                fails++;
                $display("FAIL reload_in_ready[%0d]: got %b required %b", i, in_ready_m, expr[i]);
            end
        end
    endtask

    task automatic test_reset_mid_enc();
        int unsigned cnt = 0, t = 0;
        logic [31:0] obs[6];
        logic [31:0] expv[6];
        sel = 1'b0;
        send_frame(4'b1111, 1'b0);
        while (cnt < 3 && t < 50) begin
            @(negedge clk);
            t++;
            if (busy_m) cnt++;
        end
        if (cnt < 3) begin
            tests++;
            fails++;
            $display("FAIL mid_enc_wait: busy cycles %0d required 3", cnt);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        obs[0] = 32'(ir0);   expv[0] = 0;
        obs[1] = 32'(ov0);   expv[1] = 0;
        obs[2] = 32'(oi0);   expv[2] = 0;
        obs[3] = 32'(busy0); expv[3] = 0;
        obs[4] = 32'(st0);   expv[4] = 2;
        obs[5] = 32'(ex0);   expv[5] = 2;
        for (int i = 0; i < 6; i++) begin
            tests++;
            if (obs[i] !== expv[i]) begin
                fails++;
                $display("FAIL mid_enc_reset[%0d]: got %0h required %0h", i, obs[i], expv[i]);
            end
        end
        send_frame(4'b0001, 1'b1);
        collect_frame(1'b0, 2, "post_reset");
    endtask

    initial begin
        test_reset();
        test_encode(4'b0001, 1'b0, "enc_1000");
        test_encode(4'b1111, 1'b0, "enc_1111");
        test_backpressure();
        test_encode(4'b0001, 1'b1, "p2_1000");
        test_reset_mid_enc();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
